// File: rtl/mem_arbiter_nway.sv
// N-port memory arbiter: merges NPORTS cache/DMA master ports onto one memory port.
// Fixed-priority (with starvation aging) or round-robin policy, zero-bubble re-grant on ack.
module mem_arbiter_nway #(
    parameter  int NPORTS       = 3,
    parameter  int ADDR_W       = 19,
    parameter  int DATA_W       = 16,
    parameter  int RR_MODE      = 0,
    parameter  int STARVE_LIMIT = 15,
    parameter  int GI_W         = $clog2(NPORTS),
    localparam int BE_W         = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NPORTS*ADDR_W-1:0] req_addr,
    input  logic [NPORTS*DATA_W-1:0] req_data_out,
    output logic [DATA_W-1:0]        req_data_in,
    input  logic [NPORTS-1:0]        req_access,
    output logic [NPORTS-1:0]        req_ack,
    input  logic [NPORTS-1:0]        req_wr_en,
    input  logic [NPORTS*BE_W-1:0]   req_bytesel,
    output logic [ADDR_W-1:0]        mem_m_addr,
    input  logic [DATA_W-1:0]        mem_m_data_in,
    output logic [DATA_W-1:0]        mem_m_data_out,
    output logic                     mem_m_access,
    input  logic                     mem_m_ack,
    output logic                     mem_m_wr_en,
    output logic [BE_W-1:0]          mem_m_bytesel,
    output logic                     busy,
    output logic [GI_W-1:0]          grant_idx
);

    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t           r_state;
    logic [GI_W-1:0]  r_grant;
    logic [GI_W-1:0]  r_lastGrant;
    logic [CNT_W-1:0] r_wait [NPORTS];

    logic              w_busy;
    logic              w_grantAccess;
    logic              w_ackFire;
    logic              w_takeGrant;
    logic [NPORTS-1:0] w_mask;
    logic [NPORTS-1:0] w_cand;
    logic              w_found;
    logic [GI_W-1:0]   w_winner;

    function automatic logic [GI_W-1:0] rrIndex(input logic [GI_W-1:0] last, input int k);
        return GI_W'((int'(last) + k) % NPORTS);
    endfunction

    assign w_busy        = (r_state == S_BUSY);
    assign w_grantAccess = req_access[r_grant];
    assign w_ackFire     = w_busy && w_grantAccess && mem_m_ack;
    assign w_takeGrant   = w_found && (!w_busy || w_ackFire);

    // The acked port is masked so it can never be re-granted inside its own ack cycle.
    always_comb begin
        w_mask = '0;
        if (w_ackFire)
            w_mask[r_grant] = 1'b1;
        w_cand   = req_access & ~w_mask;
        w_found  = 1'b0;
        w_winner = '0;
        if (RR_MODE != 0) begin
            for (int k = NPORTS; k >= 1; k--) begin
                if (w_cand[rrIndex(r_lastGrant, k)]) begin
                    w_found  = 1'b1;
                    w_winner = rrIndex(r_lastGrant, k);
                end
            end
        end else begin
            for (int i = NPORTS - 1; i >= 0; i--) begin
                if (w_cand[i]) begin
                    w_found  = 1'b1;
                    w_winner = GI_W'(i);
                end
            end
            if (STARVE_LIMIT > 0) begin
                for (int i = NPORTS - 1; i >= 0; i--) begin
                    if (w_cand[i] && int'(r_wait[i]) >= STARVE_LIMIT)
                        w_winner = GI_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_lastGrant <= GI_W'(NPORTS - 1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state     <= S_BUSY;
                        r_grant     <= w_winner;
                        r_lastGrant <= w_winner;
                    end
                end
                S_BUSY: begin
                    if (!w_grantAccess) begin
                        r_state <= S_IDLE;
                        r_grant <= '0;
                    end else if (w_ackFire) begin
                        if (w_found) begin
                            r_grant     <= w_winner;
                            r_lastGrant <= w_winner;
                        end else begin
                            r_state <= S_IDLE;
                            r_grant <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    // A waiting port ages only while it requests and is neither being served nor just granted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NPORTS; i++)
                r_wait[i] <= '0;
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (!req_access[i] || (w_busy && r_grant == GI_W'(i)) ||
                    (w_takeGrant && w_winner == GI_W'(i)))
                    r_wait[i] <= '0;
                else if (int'(r_wait[i]) < STARVE_LIMIT)
                    r_wait[i] <= r_wait[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        req_ack = '0;
        if (w_ackFire)
            req_ack[r_grant] = 1'b1;
    end

    assign req_data_in    = mem_m_data_in;
    assign busy           = w_busy;
    assign grant_idx      = r_grant;
    assign mem_m_access   = w_busy && w_grantAccess;
    assign mem_m_addr     = w_busy ? req_addr[int'(r_grant)*ADDR_W +: ADDR_W] : '0;
    assign mem_m_data_out = w_busy ? req_data_out[int'(r_grant)*DATA_W +: DATA_W] : '0;
    assign mem_m_wr_en    = w_busy && req_wr_en[r_grant];
    assign mem_m_bytesel  = w_busy ? req_bytesel[int'(r_grant)*BE_W +: BE_W] : '0;

endmodule

// File: tb/tb_mem_arbiter_nway.sv
// Bench for mem_arbiter_nway: a fixed-priority/aging instance and a round-robin instance
// share stimulus and are both compared every cycle against a behavioural arbiter model.
module tb_mem_arbiter_nway;

    localparam int NP = 3;
    localparam int AW = 19;
    localparam int DW = 16;
    localparam int BW = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NP*AW-1:0] reqAddr;
    logic [NP*DW-1:0] reqDataOut;
    logic [NP-1:0]    reqAccess;
    logic [NP-1:0]    reqWrEn;
    logic [NP*BW-1:0] reqBytesel;
    logic [DW-1:0]    memDataIn;
    logic             memAck;

    logic [DW-1:0] oDataIn  [2];
    logic [NP-1:0] oAck     [2];
    logic [AW-1:0] oAddr    [2];
    logic [DW-1:0] oDataOut [2];
    logic          oAccess  [2];
    logic          oWr      [2];
    logic [BW-1:0] oBe      [2];
    logic          oBusy    [2];
    logic [1:0]    oGrant   [2];

    int nChecks = 0;
    int nErrors = 0;

    // Reference model state: index 0 = fixed/aging(4), index 1 = round-robin
    bit mBusy  [2];
    int mGrant [2];
    int mLast  [2];
    int mWait  [2][NP];
    int mRr    [2] = '{0, 1};
    int mLim   [2] = '{4, 15};

    always #5 clk = ~clk;

    mem_arbiter_nway #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .STARVE_LIMIT(4)) dutFix (
        .clk(clk), .reset_n(reset_n), .req_addr(reqAddr), .req_data_out(reqDataOut),
        .req_data_in(oDataIn[0]), .req_access(reqAccess), .req_ack(oAck[0]), .req_wr_en(reqWrEn),
        .req_bytesel(reqBytesel), .mem_m_addr(oAddr[0]), .mem_m_data_in(memDataIn),
        .mem_m_data_out(oDataOut[0]), .mem_m_access(oAccess[0]), .mem_m_ack(memAck),
        .mem_m_wr_en(oWr[0]), .mem_m_bytesel(oBe[0]), .busy(oBusy[0]), .grant_idx(oGrant[0])
    );

    mem_arbiter_nway #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .STARVE_LIMIT(15)) dutRr (
        .clk(clk), .reset_n(reset_n), .req_addr(reqAddr), .req_data_out(reqDataOut),
        .req_data_in(oDataIn[1]), .req_access(reqAccess), .req_ack(oAck[1]), .req_wr_en(reqWrEn),
        .req_bytesel(reqBytesel), .mem_m_addr(oAddr[1]), .mem_m_data_in(memDataIn),
        .mem_m_data_out(oDataOut[1]), .mem_m_access(oAccess[1]), .mem_m_ack(memAck),
        .mem_m_wr_en(oWr[1]), .mem_m_bytesel(oBe[1]), .busy(oBusy[1]), .grant_idx(oGrant[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            mBusy[d]  = 1'b0;
            mGrant[d] = 0;
            mLast[d]  = NP - 1;
            for (int i = 0; i < NP; i++)
                mWait[d][i] = 0;
        end
    endtask

    function automatic int pickWinner(input int d, input int excl);
        if (mRr[d] == 0) begin
            for (int i = 0; i < NP; i++)
                if (reqAccess[i] && i != excl && mWait[d][i] >= mLim[d])
                    return i;
            for (int i = 0; i < NP; i++)
                if (reqAccess[i] && i != excl)
                    return i;
        end else begin
            for (int k = 1; k <= NP; k++) begin
                int j = (mLast[d] + k) % NP;
                if (reqAccess[j] && j != excl)
                    return j;
            end
        end
        return -1;
    endfunction

    task automatic compareDut(input int d);
        string p = (d == 0) ? "fx" : "rr";
        int    g = mBusy[d] ? mGrant[d] : 0;
        bit    fire = mBusy[d] && reqAccess[g] && memAck;
        checkOutput({p, "_busy"},   32'(oBusy[d]),    32'(mBusy[d]));
        checkOutput({p, "_grant"},  32'(oGrant[d]),   32'(g));
        checkOutput({p, "_access"}, 32'(oAccess[d]),  32'(mBusy[d] && reqAccess[g]));
        checkOutput({p, "_addr"},   32'(oAddr[d]),    mBusy[d] ? 32'(reqAddr[g*AW +: AW]) : 32'd0);
        checkOutput({p, "_wdata"},  32'(oDataOut[d]), mBusy[d] ? 32'(reqDataOut[g*DW +: DW]) : 32'd0);
        checkOutput({p, "_wr"},     32'(oWr[d]),      32'(mBusy[d] && reqWrEn[g]));
        checkOutput({p, "_be"},     32'(oBe[d]),      mBusy[d] ? 32'(reqBytesel[g*BW +: BW]) : 32'd0);
        checkOutput({p, "_ack"},    32'(oAck[d]),     fire ? (32'd1 << g) : 32'd0);
        checkOutput({p, "_rdata"},  32'(oDataIn[d]),  32'(memDataIn));
    endtask

    task automatic modelStep(input int d);
        int cur = mBusy[d] ? mGrant[d] : -1;
        int win = -1;
        if (!mBusy[d]) begin
            win = pickWinner(d, -1);
            if (win >= 0) begin
                mBusy[d]  = 1'b1;
                mGrant[d] = win;
                mLast[d]  = win;
            end
        end else if (!reqAccess[cur]) begin
            mBusy[d]  = 1'b0;
            mGrant[d] = 0;
        end else if (memAck) begin
            win = pickWinner(d, cur);
            if (win >= 0) begin
                mGrant[d] = win;
                mLast[d]  = win;
            end else begin
                mBusy[d]  = 1'b0;
                mGrant[d] = 0;
            end
        end
        for (int i = 0; i < NP; i++) begin
            if (!reqAccess[i] || i == cur || i == win)
                mWait[d][i] = 0;
            else if (mWait[d][i] < mLim[d])
                mWait[d][i]++;
        end
    endtask

    task automatic setPort(input int p, input logic [AW-1:0] a, input logic [DW-1:0] w,
                           input logic wr, input logic [BW-1:0] be);
        reqAddr[p*AW +: AW]    = a;
        reqDataOut[p*DW +: DW] = w;
        reqWrEn[p]             = wr;
        reqBytesel[p*BW +: BW] = be;
    endtask

    task automatic applyStimulus(input logic [NP-1:0] acc, input logic ack);
        reqAccess = acc;
        memAck    = ack;
        #1;
    endtask

    task automatic endCycle();
        compareDut(0);
        compareDut(1);
        modelStep(0);
        modelStep(1);
        @(negedge clk);
    endtask

    task automatic goIdle();
        repeat (2) begin
            applyStimulus(3'b000, 1'b0);
            endCycle();
        end
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        modelReset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    int agingGrant [6] = '{-1, 0, 0, 1, 1, 2};

    initial begin
        reset_n    = 1'b0;
        reqAddr    = '0;
        reqDataOut = '0;
        reqAccess  = '0;
        reqWrEn    = '0;
        reqBytesel = '0;
        memDataIn  = '0;
        memAck     = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        goIdle();

        $display("[TB] reset during an active grant");
        setPort(1, 19'h00111, 16'h1111, 1'b1, 2'b11);
        applyStimulus(3'b010, 1'b0);
        endCycle();
        applyStimulus(3'b010, 1'b0);
        checkOutput("rst_pre_access", 32'(oAccess[0]), 32'd1);
        checkOutput("rst_pre_grant", 32'(oGrant[0]), 32'd1);
        reset_n = 1'b0;
        memAck  = 1'b1;
        #1;
        checkOutput("rst_busy", 32'(oBusy[0]), 32'd0);
        checkOutput("rst_access", 32'(oAccess[0]), 32'd0);
        checkOutput("rst_addr", 32'(oAddr[0]), 32'd0);
        checkOutput("rst_wr", 32'(oWr[0]), 32'd0);
        checkOutput("rst_ack", 32'(oAck[0]), 32'd0);
        checkOutput("rst_grant", 32'(oGrant[0]), 32'd0);
        modelReset();
        @(negedge clk);
        reset_n = 1'b1;
        setPort(0, 19'h00aaa, 16'h0000, 1'b0, 2'b11);
        setPort(2, 19'h00ccc, 16'h0000, 1'b0, 2'b11);
        applyStimulus(3'b101, 1'b0);
        endCycle();
        applyStimulus(3'b101, 1'b0);
        checkOutput("rst_fx_first_win", 32'(oGrant[0]), 32'd0);
        checkOutput("rst_rr_first_win", 32'(oGrant[1]), 32'd0);
        endCycle();
        goIdle();

        $display("[TB] single read from port 2");
        setPort(2, 19'h12345, 16'h0000, 1'b0, 2'b11);
        applyStimulus(3'b100, 1'b0);
        endCycle();
        applyStimulus(3'b100, 1'b0);
        checkOutput("rd_addr", 32'(oAddr[0]), 32'h12345);
        checkOutput("rd_access", 32'(oAccess[0]), 32'd1);
        endCycle();
        applyStimulus(3'b100, 1'b0);
        endCycle();
        memDataIn = 16'hBEEF;
        applyStimulus(3'b100, 1'b1);
        checkOutput("rd_ack", 32'(oAck[0]), 32'b100);
        checkOutput("rd_data", 32'(oDataIn[0]), 32'hBEEF);
        endCycle();
        applyStimulus(3'b000, 1'b0);
        checkOutput("rd_busy_after", 32'(oBusy[0]), 32'd0);
        endCycle();
        goIdle();

        $display("[TB] write from port 1");
        setPort(1, 19'h00400, 16'hA55A, 1'b1, 2'b10);
        applyStimulus(3'b010, 1'b0);
        endCycle();
        applyStimulus(3'b010, 1'b1);
        checkOutput("wr_en", 32'(oWr[0]), 32'd1);
        checkOutput("wr_data", 32'(oDataOut[0]), 32'hA55A);
        checkOutput("wr_be", 32'(oBe[0]), 32'b10);
        checkOutput("wr_ack", 32'(oAck[0]), 32'b010);
        endCycle();
        goIdle();

        $display("[TB] round-robin rotation");
        doReset();
        applyStimulus(3'b111, 1'b1);
        endCycle();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(3'b111, 1'b1);
            checkOutput($sformatf("rr_grant%0d", k), 32'(oGrant[1]), 32'(k % 3));
            checkOutput($sformatf("rr_busy%0d", k), 32'(oBusy[1]), 32'd1);
            endCycle();
        end
        goIdle();

        $display("[TB] fixed priority with aging");
        doReset();
        for (int c = 0; c < 6; c++) begin
            applyStimulus(3'b111, (c >= 2 && c % 2 == 0) ? 1'b1 : 1'b0);
            if (c > 0)
                checkOutput($sformatf("age_grant%0d", c), 32'(oGrant[0]), 32'(agingGrant[c]));
            endCycle();
        end
        goIdle();

        $display("[TB] abort and spurious ack");
        applyStimulus(3'b001, 1'b0);
        endCycle();
        applyStimulus(3'b001, 1'b0);
        checkOutput("abort_busy_pre", 32'(oBusy[0]), 32'd1);
        endCycle();
        applyStimulus(3'b000, 1'b0);
        endCycle();
        applyStimulus(3'b000, 1'b0);
        checkOutput("abort_busy", 32'(oBusy[0]), 32'd0);
        checkOutput("abort_ack", 32'(oAck[0]), 32'd0);
        endCycle();
        applyStimulus(3'b000, 1'b1);
        checkOutput("spurious_ack", 32'(oAck[0]), 32'd0);
        endCycle();
        goIdle();

        $display("[TB] randomized traffic");
        for (int n = 0; n < 3000; n++) begin
            logic [NP-1:0] acc = reqAccess;
            for (int p = 0; p < NP; p++) begin
                if (acc[p]) begin
                    if ($urandom_range(0, 7) == 0)
                        acc[p] = 1'b0;
                end else begin
                    setPort(p, AW'($urandom), DW'($urandom), 1'($urandom), BW'($urandom));
                    if ($urandom_range(0, 2) == 0)
                        acc[p] = 1'b1;
                end
            end
            memDataIn = DW'($urandom);
            applyStimulus(acc, ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
            endCycle();
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_nway.md
# mem_arbiter_nway

Parametrised N-requester memory arbiter that merges NPORTS cache/memory master ports (I-cache, D-cache fill, D-cache victim writeback, DMA, etc.) onto the single memory-system port. It generalises the fixed 3-way Harvard arbitration:
- configurable port count, address and data width;
- selectable fixed-priority or round-robin policy;
- anti-starvation aging;
- zero-bubble back-to-back grants.

It sits between the cache controllers and the SDRAM/memory controller.

## Interface
- NPORTS, 3: number of requesters (2..8).
- ADDR_W, 19: word-address width; addresses are bits [ADDR_W:1].
- DATA_W, 16: data width; byte-select width BE_W = DATA_W/8.
- RR_MODE, 0: 0 = fixed priority (lower index wins), 1 = round-robin.
- STARVE_LIMIT, 15: wait cycles after which a requester is forced to top priority (fixed mode only); 0 disables aging.
- GI_W, $clog2(NPORTS): grant index width (derived).

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_addr  in  NPORTS*ADDR_W  port i at [i*ADDR_W +: ADDR_W].
- req_data_out  in  NPORTS*DATA_W  write data, port i at [i*DATA_W +: DATA_W].
- req_data_in  out  DATA_W  read data broadcast to all ports.
- req_access  in  NPORTS  request strobe, held until ack.
- req_ack  out  NPORTS  one-hot completion to the granted port.
- req_wr_en  in  NPORTS  1 = write.
- req_bytesel  in  NPORTS*BE_W  byte enables.
- mem_m_addr  out  ADDR_W  to memory.
- mem_m_data_in  in  DATA_W  read data from memory.
- mem_m_data_out  out  DATA_W  write data to memory.
- mem_m_access  out  1  memory request.
- mem_m_ack  in  1  memory completion.
- mem_m_wr_en  out  1  memory write enable.
- mem_m_bytesel  out  BE_W  memory byte enables.
- busy  out  1  a grant is active.
- grant_idx  out  GI_W  index of the active grant (0 when idle).

## Operation

**State machine**
- IDLE: if any req_access is high, select a winner, register grant_idx, go to BUSY.
- BUSY: mem_m_* outputs are muxed from the granted port.
  - mem_m_access = req_access[grant_idx].
  - On mem_m_ack:
    - req_ack[grant_idx]=1 in the same cycle;
    - re-arbitrate in the same cycle with the acked port masked out;
    - if another port requests, stay BUSY with the new grant (no idle cycle); otherwise go to IDLE.
  - If req_access[grant_idx] drops without an ack (protocol violation), go to IDLE next cycle. No ack is issued.

**Winner selection (priority order)**
1. Any port whose wait counter ≥ STARVE_LIMIT (lowest such index). Fixed mode only; RR_MODE=1 ignores aging.
2. Policy:
   - fixed mode: lowest-index requesting port;
   - round-robin: first requesting port at index > last_grant, wrapping modulo NPORTS.

**Wait counters**
- One per port, saturating at STARVE_LIMIT.
- Increments each cycle the port's access is high and it is not the granted port.
- Clears on grant, and when access is low.

**Output behaviour**
- req_data_in = mem_m_data_in (combinational passthrough; no reset value).
- When not BUSY, all mem_m_* outputs are 0.
- mem_m_ack outside BUSY is ignored.

**Reset (reset_n=0, any time including mid-transaction)**
- Clears: state to IDLE, busy, grant_idx, mem_m_access, mem_m_addr, mem_m_data_out, mem_m_wr_en, mem_m_bytesel, req_ack, all wait counters.
- last_grant = NPORTS-1, so port 0 wins first after reset.
- An in-flight memory transaction is abandoned; the memory controller is reset with the same reset.

## Timing
- Arbitration latency: req_access rising in cycle N gives busy=1 and mem_m_access=1 in cycle N+1.
- Ack path is combinational: mem_m_ack → req_ack, zero cycles. Read data is valid in the same cycle as req_ack.
- Back-to-back: a competing request waiting during the ack cycle is issued on mem_m_access in the very next cycle.
- A port whose access stays high after its ack is treated as a new request only from the following cycle. It is never granted twice within one ack cycle.
- No combinational path from req_access to mem_m_access while IDLE; the grant is registered.
- Worst-case wait:
  - round-robin: (NPORTS-1) transactions;
  - fixed with aging: STARVE_LIMIT cycles plus one in-flight transaction.

## Test plan
- **Reset/idle**: reset_n=0 mid-BUSY (port 1 granted, mem_m_access=1). Required: all outputs 0 asynchronously; after release, ports 0 and 2 request together and port 0 wins.
- **Single read**: port 2 reads addr 0x12345, memory acks after 3 cycles with data 0xBEEF. Required: mem_m_addr=0x12345 in cycle N+1; req_ack=3'b100 with req_data_in=0xBEEF in the ack cycle; busy=0 the cycle after.
- **Write pass-through**: port 1 writes 0xA55A with bytesel=2'b10 to 0x00400. Required: mem_m_wr_en=1, mem_m_data_out=0xA55A, mem_m_bytesel=2'b10; only req_ack[1] pulses.
- **Round-robin**: RR_MODE=1, all three ports request continuously, each ack after 1 cycle. Required: grant order 0,1,2,0,1,2 with no idle cycle between grants.
- **Fixed with aging**: RR_MODE=0, STARVE_LIMIT=4, ports 0 and 1 re-request continuously, port 2 requests from cycle 0, memory acks every 2 cycles. Required: port 2 is granted at the first re-arbitration after its counter reaches 4, ahead of ports 0 and 1.
- **Abort/spurious ack**: port 0 is granted then drops access with no ack. Required: busy=0 next cycle and no req_ack. A mem_m_ack pulse while IDLE produces no req_ack.
